stack_push_unit: RTL and testbench
==================================

# stack_push_unit

Writeback side of the stack datapath. Accepts a 24-bit result from the ULA through a valid/ready handshake and retires the operands that produced it. It saturates the result to the stack data width, writes the result into stack memory, and commits the new top-of-stack to the TOS register. It is the write-side counterpart of the operand path that feeds the ULA from the stack output and TOS register.

## Interface
Parameters:
- DATA_WIDTH, 8, stack word width.
- ADDR_WIDTH, 12, stack address / TOS width.
- ULA_WIDTH, 24, ULA result width (signed).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- res_valid  in  1  ULA result available.
- res_data  in  ULA_WIDTH  signed ULA result.
- pop_count  in  2  operands consumed by the operation (0, 1 or 2; value 3 is treated as 2).
- tos_in  in  ADDR_WIDTH  current entry count (0 = empty; the top element is at tos_in-1).
- res_ready  out  1  unit can accept a result.
- stack_we  out  1  stack memory write strobe.
- stack_addr  out  ADDR_WIDTH  write address.
- stack_wdata  out  DATA_WIDTH  write data.
- tos_we  out  1  TOS register load strobe.
- tos_out  out  ADDR_WIDTH  new entry count.
- overflow_flag  out  1  last committed result was saturated.
- underflow_err  out  1  sticky: pop_count > tos_in.
- full_err  out  1  sticky: push would exceed stack capacity.
- err_clr  in  1  clears sticky errors, leaves ERR.
- done  out  1  one-cycle pulse on commit.

## Operation
- FSM states: IDLE, CHECK, WRITE, COMMIT, ERR.
- IDLE:
  - res_ready=1.
  - On res_valid&res_ready, capture res_data, pop_count and tos_in, then go to CHECK.
  - Inputs are not sampled outside the handshake.
- CHECK:
  - Compute addr = tos_cap − pop_cap at ADDR_WIDTH+1 bits.
  - Underflow if pop_cap > tos_cap: set underflow_err, go to ERR.
  - Full if pop_cap==0 and tos_cap==2^ADDR_WIDTH−1 (the new count would wrap to 0): set full_err, go to ERR.
  - Otherwise compute the saturated value and go to WRITE.
- Saturation, signed:
  - If res_data > 2^(DATA_WIDTH−1)−1, the value is 0x7F (DATA_WIDTH=8); if res_data < −2^(DATA_WIDTH−1), it is 0x80.
  - Otherwise the value is res_data[DATA_WIDTH−1:0].
  - sat_pending = 1 when clamping occurred.
- WRITE: stack_we=1, stack_addr=addr, stack_wdata=saturated value; go to COMMIT.
- COMMIT: tos_we=1, tos_out=addr+1, done=1, overflow_flag<=sat_pending; go to IDLE.
- ERR:
  - res_ready=0; no writes.
  - err_clr=1 clears underflow_err and full_err and returns to IDLE.
- err_clr outside ERR is ignored.
- Reset in any state:
  - Go to IDLE next edge.
  - The in-flight operation is abandoned: no stack_we or tos_we after the reset edge.
  - All flags are cleared.

## Timing
- Reset values:
  - res_ready=0 during the reset cycle, 1 the cycle after.
  - stack_we=0, stack_addr=0, stack_wdata=0, tos_we=0, tos_out=0, done=0.
  - overflow_flag=0, underflow_err=0, full_err=0.
- Handshake at edge E0:
  - CHECK during cycle E0→E1.
  - stack_we high during cycle E1→E2.
  - tos_we and done high during cycle E2→E3.
  - res_ready=1 again from E3.
- Throughput: one result per 4 cycles.
- res_ready is registered; it is low in CHECK, WRITE, COMMIT and ERR.
- stack_we, tos_we and done are single-cycle pulses, each exactly once per successful operation.
- Errors are visible from the cycle after CHECK; on an error, stack_we and tos_we are never asserted.
- tos_out and stack_addr hold their last value between operations.
- overflow_flag changes only in COMMIT or on reset.

## Test plan
- Push with no pops: tos_in=5, pop_count=0, res_data=42.
  - Expect a write of 0x2A at address 5, tos_out=6, done once, overflow_flag=0, 4-cycle cadence.
- Binary op: tos_in=2, pop_count=2, res_data=300.
  - Expect a write of 0x7F at address 0, tos_out=1, overflow_flag=1.
- Negative saturation: tos_in=3, pop_count=1, res_data=−1000.
  - Expect a write of 0x80 at address 2, tos_out=3, overflow_flag=1.
  - Then push 5: overflow_flag returns to 0.
- Underflow: tos_in=1, pop_count=2.
  - Expect underflow_err=1, no stack_we or tos_we, res_ready=0.
  - After err_clr: flag 0 and res_ready=1.
- Full: tos_in=4095, pop_count=0.
  - Expect full_err=1 and no writes.
  - Control case tos_in=4095, pop_count=1: write at address 4094, tos_out=4095.
- Reset asserted in WRITE:
  - Expect no tos_we and no done, all outputs at their reset values.
  - The next push completes normally.

Source files
------------

// File: rtl/stack_push_unit.sv
// ============================================================================
//  Module      : stack_push_unit
//  Description : Writeback side of the stack datapath. Saturates a ULA result,
//                writes it to stack memory and commits the new top-of-stack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_push_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int ULA_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res_valid,
    input  logic [ULA_WIDTH-1:0]  res_data,
    input  logic [1:0]            pop_count,
    input  logic [ADDR_WIDTH-1:0] tos_in,
    output logic                  res_ready,
    output logic                  stack_we,
    output logic [ADDR_WIDTH-1:0] stack_addr,
    output logic [DATA_WIDTH-1:0] stack_wdata,
    output logic                  tos_we,
    output logic [ADDR_WIDTH-1:0] tos_out,
    output logic                  overflow_flag,
    output logic                  underflow_err,
    output logic                  full_err,
    input  logic                  err_clr,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        WRITE  = 3'd2,
        COMMIT = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic signed [ULA_WIDTH-1:0] c_sat_max = ULA_WIDTH'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [ULA_WIDTH-1:0] c_sat_min = ULA_WIDTH'(-(2**(DATA_WIDTH-1)));

    state_t r_state;
    state_t w_state_next;

    logic [ULA_WIDTH-1:0]  r_res;
    logic [1:0]            r_pop;
    logic [ADDR_WIDTH-1:0] r_tos;
    logic                  r_sat_pending;

    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_addr;
    logic                  w_underflow;
    logic                  w_full;
    logic                  w_sat_hi;
    logic                  w_sat_lo;
    logic [DATA_WIDTH-1:0] w_sat_val;

    assign w_accept    = res_valid && res_ready && (r_state == IDLE);
    assign w_addr      = {1'b0, r_tos} - {{(ADDR_WIDTH-1){1'b0}}, r_pop};
    assign w_underflow = {{(ADDR_WIDTH-2){1'b0}}, r_pop} > r_tos;
    assign w_full      = (r_pop == 2'd0) && (&r_tos);
    assign w_sat_hi    = $signed(r_res) > c_sat_max;
    assign w_sat_lo    = $signed(r_res) < c_sat_min;

    always_comb begin
        w_sat_val = r_res[DATA_WIDTH-1:0];
        if (w_sat_hi) begin
            w_sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_sat_lo) begin
            w_sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = CHECK;
            CHECK:   w_state_next = (w_underflow || w_full) ? ERR : WRITE;
            WRITE:   w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            ERR:     if (err_clr) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res         <= '0;
            r_pop         <= '0;
            r_tos         <= '0;
            r_sat_pending <= 1'b0;
            res_ready     <= 1'b0;
            stack_we      <= 1'b0;
            stack_addr    <= '0;
            stack_wdata   <= '0;
            tos_we        <= 1'b0;
            tos_out       <= '0;
            done          <= 1'b0;
            overflow_flag <= 1'b0;
            underflow_err <= 1'b0;
            full_err      <= 1'b0;
        end else begin
            res_ready <= (w_state_next == IDLE);
            stack_we  <= 1'b0;
            tos_we    <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_res <= res_data;
                        r_pop <= (pop_count == 2'd3) ? 2'd2 : pop_count;
                        r_tos <= tos_in;
                    end
                end
                CHECK: begin
                    // Underflow has priority; full can only occur with no pops.
                    if (w_underflow) begin
                        underflow_err <= 1'b1;
                    end else if (w_full) begin
                        full_err <= 1'b1;
                    end else begin
                        stack_we      <= 1'b1;
                        stack_addr    <= w_addr[ADDR_WIDTH-1:0];
                        stack_wdata   <= w_sat_val;
                        r_sat_pending <= w_sat_hi || w_sat_lo;
                    end
                end
                WRITE: begin
                    tos_we  <= 1'b1;
                    done    <= 1'b1;
                    tos_out <= stack_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
                COMMIT: begin
                    overflow_flag <= r_sat_pending;
                end
                ERR: begin
                    if (err_clr) begin
                        underflow_err <= 1'b0;
                        full_err      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stack_push_unit.sv
// ============================================================================
//  Module      : tb_stack_push_unit
//  Description : Directed self-checking bench for stack_push_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_push_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid;
    logic [23:0] res_data;
    logic [1:0]  pop_count;
    logic [11:0] tos_in;
    logic        res_ready;
    logic        stack_we;
    logic [11:0] stack_addr;
    logic [7:0]  stack_wdata;
    logic        tos_we;
    logic [11:0] tos_out;
    logic        overflow_flag;
    logic        underflow_err;
    logic        full_err;
    logic        err_clr;
    logic        done;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int tos_cnt = 0;
    int done_cnt = 0;

    stack_push_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .ULA_WIDTH(24)) dut (
        .clk           (clk),
        .reset         (reset),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .pop_count     (pop_count),
        .tos_in        (tos_in),
        .res_ready     (res_ready),
        .stack_we      (stack_we),
        .stack_addr    (stack_addr),
        .stack_wdata   (stack_wdata),
        .tos_we        (tos_we),
        .tos_out       (tos_out),
        .overflow_flag (overflow_flag),
        .underflow_err (underflow_err),
        .full_err      (full_err),
        .err_clr       (err_clr),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (stack_we) we_cnt   <= we_cnt + 1;
        if (tos_we)   tos_cnt  <= tos_cnt + 1;
        if (done)     done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic handshake(input string tag, input logic [23:0] d, input logic [1:0] p,
                             input logic [11:0] t);
        for (int i = 0; i < 8 && !res_ready; i++) tick();
        chk({tag, "_ready"}, 32'(res_ready), 32'd1);
        res_valid = 1'b1;
        res_data  = d;
        pop_count = p;
        tos_in    = t;
        tick();
        res_valid = 1'b0;
        res_data  = 24'hABCDEF;
        pop_count = 2'd0;
        tos_in    = 12'h000;
        chk({tag, "_busy"}, 32'(res_ready), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [23:0] d, input logic [1:0] p,
                         input logic [11:0] t, input logic [11:0] ea, input logic [7:0] ed,
                         input logic [11:0] et, input logic eo);
        int we0, tos0, done0;
        we0 = we_cnt; tos0 = tos_cnt; done0 = done_cnt;
        handshake(tag, d, p, t);
        tick();
        chk({tag, "_we"},    32'(stack_we),    32'd1);
        chk({tag, "_addr"},  32'(stack_addr),  32'(ea));
        chk({tag, "_wdata"}, 32'(stack_wdata), 32'(ed));
        tick();
        chk({tag, "_tos_we"}, 32'({tos_we, done, stack_we}), 32'b110);
        chk({tag, "_tos"},    32'(tos_out), 32'(et));
        tick();
        chk({tag, "_ready_back"}, 32'({res_ready, tos_we, done}), 32'b100);
        chk({tag, "_ovf"},        32'(overflow_flag), 32'(eo));
        chk({tag, "_pulses"}, 32'((we_cnt - we0) * 100 + (tos_cnt - tos0) * 10 + (done_cnt - done0)),
            32'd111);
    endtask

    initial begin
        int we0, tos0;
        reset = 1'b1; res_valid = 1'b0; res_data = '0; pop_count = '0;
        tos_in = '0; err_clr = 1'b0;
        tick();
        chk("reset_outputs", 32'({res_ready, stack_we, tos_we, done, overflow_flag,
                                  underflow_err, full_err}), 32'd0);
        chk("reset_addr_tos", 32'({stack_addr, tos_out, stack_wdata}), 32'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 32'(res_ready), 32'd1);

        do_op("push42",   24'd42,        2'd0, 12'd5, 12'd5, 8'h2A, 12'd6, 1'b0);
        do_op("binop300", 24'd300,       2'd2, 12'd2, 12'd0, 8'h7F, 12'd1, 1'b1);
        do_op("neg1000",  -24'sd1000,    2'd1, 12'd3, 12'd2, 8'h80, 12'd3, 1'b1);
        do_op("push5",    24'd5,         2'd0, 12'd3, 12'd3, 8'h05, 12'd4, 1'b0);
        do_op("max127",   24'd127,       2'd1, 12'd4, 12'd3, 8'h7F, 12'd4, 1'b0);
        do_op("min128",   -24'sd128,     2'd0, 12'd7, 12'd7, 8'h80, 12'd8, 1'b0);
        do_op("neg1",     24'hFFFFFF,    2'd3, 12'd4, 12'd2, 8'hFF, 12'd3, 1'b0);
        do_op("over128",  24'd128,       2'd1, 12'd9, 12'd8, 8'h7F, 12'd9, 1'b1);

        // Underflow: tos 1, pop 2
        we0 = we_cnt; tos0 = tos_cnt;
        handshake("under", 24'd1, 2'd2, 12'd1);
        tick();
        chk("under_flag", 32'({underflow_err, full_err}), 32'b10);
        tick(); tick(); tick();
        chk("under_hold", 32'({res_ready, stack_we, tos_we, done}), 32'd0);
        chk("under_addr_held", 32'({stack_addr, tos_out}), {8'd0, 12'd8, 12'd9});
        chk("under_no_writes", 32'((we_cnt - we0) + (tos_cnt - tos0)), 32'd0);
        chk("under_ovf_kept", 32'(overflow_flag), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("under_clr", 32'({res_ready, underflow_err}), 32'b10);

        // Full: tos 4095, push
        we0 = we_cnt; tos0 = tos_cnt;
        handshake("full", 24'd3, 2'd0, 12'd4095);
        tick(); tick();
        chk("full_flag", 32'({full_err, underflow_err, res_ready}), 32'b100);
        chk("full_no_writes", 32'((we_cnt - we0) + (tos_cnt - tos0)), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("full_clr", 32'({res_ready, full_err}), 32'b10);
        do_op("full_ctrl", 24'd9, 2'd1, 12'd4095, 12'd4094, 8'h09, 12'd4095, 1'b0);

        // Saturating op so overflow_flag is 1 going into the reset test
        do_op("pre_rst", 24'd1000, 2'd0, 12'd10, 12'd10, 8'h7F, 12'd11, 1'b1);

        // Reset while in WRITE
        tos0 = tos_cnt;
        handshake("rst_wr", 24'd20, 2'd0, 12'd20);
        tick();
        chk("rst_wr_in_write", 32'(stack_we), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_wr_outputs", 32'({res_ready, stack_we, tos_we, done, overflow_flag,
                                   underflow_err, full_err}), 32'd0);
        chk("rst_wr_addr_tos", 32'({stack_addr, tos_out, stack_wdata}), 32'd0);
        tick(); tick();
        chk("rst_wr_no_commit", 32'(tos_cnt - tos0), 32'd0);
        do_op("post_rst", 24'd33, 2'd1, 12'd6, 12'd5, 8'h21, 12'd6, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
